// File: rtl/antilog2_stream_if.sv
// antilog2_stream_if
//   Bundles the sample-in and result-out streams of antilog2_stream.
//   master : the environment, drives din/din_valid/dout_ready and observes the rest
//   slave  : the anti-log block itself
// Signals:
//   din        exponent x = din / 2^FRAC_W, unsigned
//   din_valid  din qualifier
//   din_ready  block accepts din this cycle
//   dout       2^x with DOUT_FRAC_W fraction bits
//   dout_valid dout qualifier
//   dout_ready sink accepts dout this cycle
//   dout_ovf   dout is saturated, qualified by dout_valid
//   ovf_cnt    saturating count of delivered overflowed samples
interface antilog2_stream_if #(
    parameter int INT_W       = 6,
    parameter int FRAC_W      = 10,
    parameter int DOUT_INT_W  = 16,
    parameter int DOUT_FRAC_W = 8
);
    logic [INT_W+FRAC_W-1:0]           din;
    logic                              din_valid;
    logic                              din_ready;
    logic [DOUT_INT_W+DOUT_FRAC_W-1:0] dout;
    logic                              dout_valid;
    logic                              dout_ready;
    logic                              dout_ovf;
    logic [15:0]                       ovf_cnt;

    modport master (
        output din, din_valid, dout_ready,
        input  din_ready, dout, dout_valid, dout_ovf, ovf_cnt
    );

    modport slave (
        input  din, din_valid, dout_ready,
        output din_ready, dout, dout_valid, dout_ovf, ovf_cnt
    );
endinterface

// File: rtl/antilog2_stream.sv
// antilog2_stream
//   Streaming base-2 anti-logarithm. The exponent is split into an integer
//   part e, a LUT index k and a residue r. One octave of 2^(k/2^LUT_AW) is
//   held in a LUT built at elaboration; the octave value is then scaled by a
//   left shift of e. Results whose integer part cannot be represented
//   saturate to all ones and are counted.
//   Pipeline: S1 field split, S2 LUT read, S3 interpolate/shift/saturate.
//   All stages advance together on en = !dout_valid | dout_ready.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    antilog2_stream_if slave modport (din/dout streams, ovf flag, ovf counter)
// Build option:
//   ANTILOG2_INTERP_EN  when defined, linearly interpolate between LUT entries
//                       using the residue r; otherwise r is ignored.
module antilog2_stream #(
    parameter int INT_W       = 6,
    parameter int FRAC_W      = 10,
    parameter int LUT_AW      = 6,
    parameter int MANT_W      = 23,
    parameter int DOUT_INT_W  = 16,
    parameter int DOUT_FRAC_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    antilog2_stream_if.slave   bus
);

    localparam int DIN_W  = INT_W + FRAC_W;
    localparam int RW     = FRAC_W - LUT_AW;
    localparam int DOUT_W = DOUT_INT_W + DOUT_FRAC_W;
    localparam int LUT_N  = 1 << LUT_AW;
    localparam int SHR    = MANT_W - DOUT_FRAC_W;
    // 1.m can reach 2.0 when interpolating up to the top entry
    localparam int SUM_W  = MANT_W + 2;
    // wide enough for the largest unsaturated shift (e = DOUT_INT_W-1)
    localparam int SH_W   = SUM_W + DOUT_INT_W;

`ifdef ANTILOG2_INTERP_EN
    localparam int LUT_ENTRIES = LUT_N + 1;
`else
    localparam int LUT_ENTRIES = LUT_N;
`endif

    typedef logic [MANT_W:0] mant_t;

    // Fractional part of 2^(j/2^LUT_AW), rounded to MANT_W bits.
    function automatic mant_t lut_entry(input int j);
        real x;
        x = (2.0 ** (real'(j) / real'(LUT_N)) - 1.0) * (2.0 ** real'(MANT_W));
        return mant_t'($rtoi(x + 0.5));
    endfunction

    mant_t lut [LUT_ENTRIES];

    for (genvar j = 0; j < LUT_ENTRIES; j++) begin : g_lut
        localparam mant_t LV = lut_entry(j);
        assign lut[j] = LV;
    end

    logic en;

    logic               v1;
    logic [INT_W-1:0]   s1_e;
    logic [LUT_AW-1:0]  s1_k;

    logic               v2;
    logic [INT_W-1:0]   s2_e;
    mant_t              s2_lo;

`ifdef ANTILOG2_INTERP_EN
    logic [RW-1:0]      s1_r;
    logic [RW-1:0]      s2_r;
    mant_t              s2_hi;
    logic [LUT_AW:0]    k_next;
`endif

    logic               dout_valid_q;
    logic [DOUT_W-1:0]  dout_q;
    logic               ovf_q;
    logic [15:0]        cnt_q;

    mant_t              m;
    logic [SUM_W-1:0]   sum;
    logic [SH_W-1:0]    shifted;
    logic [DOUT_W-1:0]  res;
    logic               sat;

    // Whole pipe freezes when the output holds an unaccepted sample.
    assign en            = !dout_valid_q || bus.dout_ready;
    assign bus.din_ready = en;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1   <= 1'b0;
            s1_e <= '0;
            s1_k <= '0;
`ifdef ANTILOG2_INTERP_EN
            s1_r <= '0;
`endif
        end else if (en) begin
            v1 <= bus.din_valid;
            if (bus.din_valid) begin
                s1_e <= bus.din[DIN_W-1:FRAC_W];
                s1_k <= bus.din[FRAC_W-1 -: LUT_AW];
`ifdef ANTILOG2_INTERP_EN
                s1_r <= bus.din[RW-1:0];
`endif
            end
        end
    end

`ifdef ANTILOG2_INTERP_EN
    assign k_next = {1'b0, s1_k} + 1'b1;
`else
    // Low fraction bits only matter when interpolating.
    if (RW > 0) begin : g_unused_r
        logic unused_r;
        assign unused_r = ^bus.din[RW-1:0];
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v2    <= 1'b0;
            s2_e  <= '0;
            s2_lo <= '0;
`ifdef ANTILOG2_INTERP_EN
            s2_hi <= '0;
            s2_r  <= '0;
`endif
        end else if (en) begin
            v2 <= v1;
            if (v1) begin
                s2_e  <= s1_e;
                s2_lo <= lut[s1_k];
`ifdef ANTILOG2_INTERP_EN
                s2_hi <= lut[k_next];
                s2_r  <= s1_r;
`endif
            end
        end
    end

`ifdef ANTILOG2_INTERP_EN
    localparam int PROD_W = MANT_W + 1 + RW;
    typedef logic [PROD_W-1:0] prod_t;
    mant_t diff;
    prod_t prod;
`endif

    always_comb begin
`ifdef ANTILOG2_INTERP_EN
        // LUT is monotonic, so the step to the next entry is never negative.
        diff = s2_hi - s2_lo;
        prod = prod_t'(diff) * prod_t'(s2_r);
        m    = s2_lo + mant_t'(prod >> RW);
`else
        m    = s2_lo;
`endif
        sum     = SUM_W'(m) + (SUM_W'(1) << MANT_W);
        shifted = SH_W'(sum) << s2_e;
        res     = DOUT_W'(shifted >> SHR);
        sat     = int'(s2_e) >= DOUT_INT_W;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout_valid_q <= 1'b0;
            dout_q       <= '0;
            ovf_q        <= 1'b0;
        end else if (en) begin
            dout_valid_q <= v2;
            if (v2) begin
                dout_q <= sat ? '1 : res;
                ovf_q  <= sat;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (dout_valid_q && bus.dout_ready && ovf_q && (cnt_q != 16'hFFFF)) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.dout_ovf   = ovf_q;
    assign bus.ovf_cnt    = cnt_q;

endmodule

// File: doc/antilog2_stream.md
# antilog2_stream

Parametrised streaming base-2 anti-logarithm: converts an unsigned fixed-point exponent into 2^x in fixed point, using a one-octave LUT plus barrel shifter. Optional linear interpolation between LUT entries. Three-stage pipeline with valid/ready handshakes on both sides, output saturation and an overflow event counter. Sits downstream of log-domain gain/level processing, feeding linear-domain datapaths.

## Interface
- INT_W, 6, integer bits of DIN
- FRAC_W, 10, fraction bits of DIN
- LUT_AW, 6, LUT address bits; LUT_AW ≤ FRAC_W
- MANT_W, 23, LUT mantissa bits
- DOUT_INT_W, 16, integer bits of DOUT
- DOUT_FRAC_W, 8, fraction bits of DOUT; DOUT_FRAC_W ≤ MANT_W
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- DIN  in  INT_W+FRAC_W  exponent x = DIN / 2^FRAC_W, unsigned
- DIN_VALID  in  1  DIN qualifier
- DIN_READY  out  1  block accepts DIN this cycle
- DOUT  out  DOUT_INT_W+DOUT_FRAC_W  2^x, DOUT_FRAC_W fraction bits
- DOUT_VALID  out  1  DOUT qualifier
- DOUT_READY  in  1  sink accepts DOUT this cycle
- DOUT_OVF  out  1  DOUT is saturated; valid with DOUT_VALID
- OVF_CNT  out  16  saturating count of overflowed samples delivered

## Operation
- Fields: e = DIN[INT_W+FRAC_W-1:FRAC_W]; k = DIN[FRAC_W-1 -: LUT_AW]; r = low RW = FRAC_W-LUT_AW bits.
- LUT: L[j] = round((2^(j/2^LUT_AW) - 1) * 2^MANT_W), j = 0..2^LUT_AW; L[2^LUT_AW] = 2^MANT_W. Contents generated from parameters at elaboration, not hand-entered.
- Mantissa m: see Configuration. m is MANT_W+1 bits wide to hold interpolation carry.
- Result: DOUT = ((2^MANT_W + m) << e) >> (MANT_W - DOUT_FRAC_W), truncated, no rounding.
- Saturation: if e ≥ DOUT_INT_W, DOUT = all ones, DOUT_OVF = 1; otherwise DOUT_OVF = 0. Intermediate shift width sized so no bits are lost before the check.
- OVF_CNT increments by 1 on each output handshake (DOUT_VALID & DOUT_READY) with DOUT_OVF = 1; holds at 0xFFFF.
- Stages: S1 registers e, k, r; S2 registers L[k], L[k+1], e, r; S3 computes m, shift and saturation and registers DOUT, DOUT_OVF.
- Flow control: global advance en = !DOUT_VALID | DOUT_READY; DIN_READY = en. When en = 0, all stage registers and valid bits hold. Bubbles travel through and are not collapsed.
- Input accepted when DIN_VALID & DIN_READY; DIN ignored otherwise.

## Timing
- Reset (rst_n = 0 at rising edge): all stage valids 0, DOUT = 0, DOUT_VALID = 0, DOUT_OVF = 0, OVF_CNT = 0. DIN_READY = 1 the cycle after reset releases (en true with DOUT_VALID = 0).
- Reset mid-operation: in-flight samples discarded, no partial output.
- Latency: sample accepted at edge t appears on DOUT with DOUT_VALID = 1 after edge t+2, with no stall.
- Throughput: 1 sample/cycle while DOUT_READY = 1.
- DOUT, DOUT_OVF stable while DOUT_VALID & !DOUT_READY.
- Simultaneous output handshake and new input: both occur in the same cycle, with no bubble inserted.
- DIN_READY is combinational from DOUT_READY and DOUT_VALID. There is no other combinational input-to-output path.

## Configuration
- ANTILOG2_INTERP_EN defined: m = L[k] + (((L[k+1] - L[k]) * r) >> RW). Requires RW ≥ 1; the multiplier sits in S3.
- Undefined: m = L[k]; r is ignored (truncation to LUT grid). L[k+1] register and multiplier are removed.
- Handshake, latency and saturation are identical in both builds.

## Test plan
- Defaults, DIN = 0 -> DOUT = 256 (1.0), DOUT_OVF = 0, DOUT_VALID after edge t+2.
- DIN = 4<<10 -> DOUT = 4096; DIN = (15<<10)|(63<<4) -> DOUT = 16596492 (no interp).
- DIN = (0<<10)|8 (k = 0, r = 8) -> DOUT = 257 with ANTILOG2_INTERP_EN, 256 without.
- DIN = 16<<10 and DIN = 63<<10 -> DOUT = 0xFFFFFF, DOUT_OVF = 1; OVF_CNT = 2 after both handshakes; 70000 overflow handshakes -> OVF_CNT = 0xFFFF.
- Stream 1000 random DIN with random DIN_VALID/DOUT_READY -> outputs match model, in order, none lost or duplicated; DOUT stable while stalled; DIN_READY = 0 whenever DOUT_VALID & !DOUT_READY.
- Assert rst_n = 0 with 3 samples in flight -> no DOUT_VALID afterwards until new input; all outputs at reset values.
